// File: rtl/regfile_access_ctrl_if.sv
// Bus bundle between the register-file access controller and its neighbours:
// decode operand requests/responses, two writeback sources and the regfile ports.
interface regfile_access_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 4
);
   logic                  rd_req_valid;
   logic                  rd_req_ready;
   logic [2:0]            rd_mask;
   logic [ADDR_WIDTH-1:0] rd_addr0;
   logic [ADDR_WIDTH-1:0] rd_addr1;
   logic [ADDR_WIDTH-1:0] rd_addr2;
   logic                  rd_rsp_valid;
   logic                  rd_rsp_ready;
   logic [DATA_WIDTH-1:0] rd_data0;
   logic [DATA_WIDTH-1:0] rd_data1;
   logic [DATA_WIDTH-1:0] rd_data2;
   logic                  wb0_valid;
   logic [ADDR_WIDTH-1:0] wb0_addr;
   logic [DATA_WIDTH-1:0] wb0_data;
   logic                  wb0_ready;
   logic                  wb1_valid;
   logic [ADDR_WIDTH-1:0] wb1_addr;
   logic [DATA_WIDTH-1:0] wb1_data;
   logic                  wb1_ready;
   logic [ADDR_WIDTH-1:0] rf_read_addr;
   logic [DATA_WIDTH-1:0] rf_read_data;
   logic                  rf_write_en;
   logic [ADDR_WIDTH-1:0] rf_write_addr;
   logic [DATA_WIDTH-1:0] rf_write_data;
   logic                  pc_write;

   modport slave (
      input  rd_req_valid, rd_mask, rd_addr0, rd_addr1, rd_addr2, rd_rsp_ready,
      input  wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
      input  rf_read_data,
      output rd_req_ready, rd_rsp_valid, rd_data0, rd_data1, rd_data2,
      output wb0_ready, wb1_ready, rf_read_addr,
      output rf_write_en, rf_write_addr, rf_write_data, pc_write
   );

   modport master (
      output rd_req_valid, rd_mask, rd_addr0, rd_addr1, rd_addr2, rd_rsp_ready,
      output wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
      output rf_read_data,
      input  rd_req_ready, rd_rsp_valid, rd_data0, rd_data1, rd_data2,
      input  wb0_ready, wb1_ready, rf_read_addr,
      input  rf_write_en, rf_write_addr, rf_write_data, pc_write
   );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Owns both register-file ports: sequences up to three operand reads into one
// bundle and round-robin arbitrates the ALU/LSU writebacks onto the write port.
module regfile_access_ctrl #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter bit          BYPASS_EN  = 1'b1
) (
   input logic                  clk,
   input logic                  rst_n,
   regfile_access_ctrl_if.slave bus
);

   typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_RD2, S_RESP} state_e;

   state_e                state_q, state_d;
   logic [2:0]            mask_q, mask_d;
   logic [ADDR_WIDTH-1:0] addr_q [3];
   logic [ADDR_WIDTH-1:0] addr_d [3];
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [DATA_WIDTH-1:0] data_q [3];
   logic [DATA_WIDTH-1:0] data_d [3];
   logic                  rr_q, rr_d;   // 1: wb0 was granted last, so wb1 wins a tie

   logic                  req_ready;
   logic                  gnt0, gnt1;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [1:0]            nxt;
   logic                  advance;

   // Index of the lowest set mask bit at or above 'from'; 3 means none left.
   function automatic logic [1:0] first_slot(input logic [2:0] m, input logic [1:0] from);
      first_slot = 2'd3;
      for (int unsigned i = 0; i < 3; i++) begin
         if (m[i] && (i >= 32'(from)) && (first_slot == 2'd3)) first_slot = 2'(i);
      end
   endfunction

   function automatic state_e slot_state(input logic [1:0] idx);
      case (idx)
         2'd0:    slot_state = S_RD0;
         2'd1:    slot_state = S_RD1;
         2'd2:    slot_state = S_RD2;
         default: slot_state = S_RESP;
      endcase
   endfunction

   // Write arbiter
   always_comb begin
      gnt0 = rst_n && bus.wb0_valid && (!bus.wb1_valid || !rr_q);
      gnt1 = rst_n && bus.wb1_valid && (!bus.wb0_valid || rr_q);
      wr_en = gnt0 || gnt1;
      wr_addr = '0;
      wr_data = '0;
      if (gnt1) begin
         wr_addr = bus.wb1_addr;
         wr_data = bus.wb1_data;
      end else if (gnt0) begin
         wr_addr = bus.wb0_addr;
         wr_data = bus.wb0_data;
      end
      rr_d = rr_q;
      if (wr_en) rr_d = gnt0;
   end

   assign rd_word = (BYPASS_EN && wr_en && (wr_addr == raddr_q)) ? wr_data : bus.rf_read_data;
   assign req_ready = rst_n && (state_q == S_IDLE);

   // Read sequencer
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      addr_d  = addr_q;
      raddr_d = raddr_q;
      data_d  = data_q;
      nxt     = 2'd3;
      advance = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.rd_req_valid && req_ready) begin
               mask_d    = bus.rd_mask;
               addr_d[0] = bus.rd_addr0;
               addr_d[1] = bus.rd_addr1;
               addr_d[2] = bus.rd_addr2;
               data_d    = '{default: '0};
               nxt       = first_slot(bus.rd_mask, 2'd0);
               advance   = 1'b1;
            end
         end
         S_RD0: begin
            data_d[0] = rd_word;
            nxt       = first_slot(mask_q, 2'd1);
            advance   = 1'b1;
         end
         S_RD1: begin
            data_d[1] = rd_word;
            nxt       = first_slot(mask_q, 2'd2);
            advance   = 1'b1;
         end
         S_RD2: begin
            data_d[2] = rd_word;
            advance   = 1'b1;
         end
         S_RESP: begin
            if (bus.rd_rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (advance) begin
         state_d = slot_state(nxt);
         if (nxt != 2'd3) raddr_d = addr_d[nxt];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mask_q  <= '0;
         addr_q  <= '{default: '0};
         raddr_q <= '0;
         data_q  <= '{default: '0};
         rr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         addr_q  <= addr_d;
         raddr_q <= raddr_d;
         data_q  <= data_d;
         rr_q    <= rr_d;
      end
   end

   assign bus.rd_req_ready  = req_ready;
   assign bus.rd_rsp_valid  = (state_q == S_RESP);
   assign bus.rd_data0      = data_q[0];
   assign bus.rd_data1      = data_q[1];
   assign bus.rd_data2      = data_q[2];
   assign bus.rf_read_addr  = raddr_q;
   assign bus.wb0_ready     = gnt0;
   assign bus.wb1_ready     = gnt1;
   assign bus.rf_write_en   = wr_en;
   assign bus.rf_write_addr = wr_addr;
   assign bus.rf_write_data = wr_data;
   assign bus.pc_write      = wr_en && (wr_addr == ADDR_WIDTH'(15));

endmodule
